// File: rtl/pulp_io_evt_router_if.sv
// APB slave port and serialised event-ID stream of pulp_io_evt_router.
// slave = router side, master = SoC/bench side.
interface pulp_io_evt_router_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int EVT_ID_WIDTH   = 8
);
  logic [APB_ADDR_WIDTH-1:0] apb_paddr;
  logic [31:0]               apb_pwdata;
  logic                      apb_pwrite;
  logic                      apb_psel;
  logic                      apb_penable;
  logic [31:0]               apb_prdata;
  logic                      apb_pready;
  logic                      apb_pslverr;
  logic                      event_valid_o;
  logic [EVT_ID_WIDTH-1:0]   event_data_o;
  logic                      event_ready_i;

  modport slave (
    input  apb_paddr, apb_pwdata, apb_pwrite, apb_psel, apb_penable,
    output apb_prdata, apb_pready, apb_pslverr,
    output event_valid_o, event_data_o,
    input  event_ready_i
  );

  modport master (
    output apb_paddr, apb_pwdata, apb_pwrite, apb_psel, apb_penable,
    input  apb_prdata, apb_pready, apb_pslverr,
    input  event_valid_o, event_data_o,
    output event_ready_i
  );
endinterface

// File: rtl/pulp_io_evt_router.sv
// Peripheral event router: mask, pending latch, round-robin grant into a FWFT FIFO, APB control.
// Optional EVT_ROUTER_TIMESTAMP_EN stores a 16-bit free-running timestamp with each queued id.
module pulp_io_evt_router #(
  parameter int N_PERIPH       = 32,
  parameter int EVT_PER_PERIPH = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int EVT_ID_WIDTH   = 8,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                                     sys_clk_i,
  input  logic                                     sys_rst_i,
  pulp_io_evt_router_if.slave                      bus,
  input  logic [N_PERIPH-1:0][EVT_PER_PERIPH-1:0]  events_i,
  output logic                                     overflow_irq_o
`ifdef EVT_ROUTER_TIMESTAMP_EN
  ,
  output logic [15:0]                              event_ts_o
`endif
);
  localparam int NE = N_PERIPH * EVT_PER_PERIPH;
  localparam int NW = (NE + 31) / 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef EVT_ROUTER_TIMESTAMP_EN
  localparam int EW = EVT_ID_WIDTH + 16;
`else
  localparam int EW = EVT_ID_WIDTH;
`endif

  generate
    if (NE > 2 ** EVT_ID_WIDTH) begin : g_bad_id_width
      $error("N_PERIPH*EVT_PER_PERIPH exceeds 2**EVT_ID_WIDTH");
    end
    if (NW > 32) begin : g_bad_mask_words
      $error("more than 32 mask words");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [NE-1:0]           evt_flat;
  logic [NE-1:0]           mask_q, mask_d, pend_q, pend_d;
  logic [EVT_ID_WIDTH-1:0] rr_q, rr_d, ovf_id_q, ovf_id_d;
  logic                    ovf_q, ovf_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [EW-1:0]           mem_d [FIFO_DEPTH];
`ifdef EVT_ROUTER_TIMESTAMP_EN
  logic [15:0]             ts_q, ts_d;
`endif

  // Packed [periph][line] flattens to id = periph*EVT_PER_PERIPH + line.
  assign evt_flat = events_i;

  function automatic logic [EVT_ID_WIDTH-1:0] first_set(input logic [NE-1:0] v);
    logic [EVT_ID_WIDTH-1:0] r;
    r = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (v[i]) r = EVT_ID_WIDTH'(i);
    end
    return r;
  endfunction

  logic                      acc, wr_en, rd_en;
  logic                      is_mask, is_status, is_ovf, is_sw, sw_ok, full, empty;
  logic [APB_ADDR_WIDTH-3:0] widx;
  logic [EVT_ID_WIDTH-1:0]   sw_id;
  logic [NW*32-1:0]          mask_pad, mask_wr;

  always_comb begin
    acc       = bus.apb_psel & bus.apb_penable;
    wr_en     = acc & bus.apb_pwrite;
    rd_en     = acc & ~bus.apb_pwrite;
    widx      = bus.apb_paddr[APB_ADDR_WIDTH-1:2];
    is_mask   = (bus.apb_paddr[1:0] == 2'b00) && (32'(widx) < NW);
    is_status = (bus.apb_paddr == APB_ADDR_WIDTH'('h80));
    is_ovf    = (bus.apb_paddr == APB_ADDR_WIDTH'('h84));
    is_sw     = (bus.apb_paddr == APB_ADDR_WIDTH'('h88));
    sw_id     = bus.apb_pwdata[EVT_ID_WIDTH-1:0];
    sw_ok     = 32'(sw_id) < NE;
    full      = (cnt_q == CW'(FIFO_DEPTH));
    empty     = (cnt_q == '0);
    mask_pad  = '0;
    mask_pad[NE-1:0] = mask_q;
    mask_wr   = mask_pad;
    bus.apb_prdata = '0;
    for (int k = 0; k < NW; k++) begin
      if (is_mask && (32'(widx) == k)) begin
        if (rd_en) bus.apb_prdata = mask_pad[k*32 +: 32];
        if (wr_en) mask_wr[k*32 +: 32] = bus.apb_pwdata;
      end
    end
    if (rd_en && is_status) bus.apb_prdata = {16'h0, 8'(cnt_q), 5'h0, full, empty, ovf_q};
    if (rd_en && is_ovf)    bus.apb_prdata = 32'(ovf_id_q);
    bus.apb_pslverr = acc && (!(is_mask | is_status | is_ovf | is_sw) ||
                              (wr_en && is_sw && !sw_ok));
  end

  logic                    pop, push, push_ok;
  logic [NE-1:0]           sw_vec, set_vec, ovf_vec, grant_vec, rr_mask, hi_pend;
  logic [EVT_ID_WIDTH-1:0] grant_id;
  logic [EW-1:0]           entry;

  always_comb begin
    mask_d   = mask_wr[NE-1:0];
    rr_d     = rr_q;
    ovf_d    = ovf_q;
    ovf_id_d = ovf_id_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
`ifdef EVT_ROUTER_TIMESTAMP_EN
    ts_d     = ts_q + 16'd1;
`endif

    pop     = (cnt_q != '0) && bus.event_ready_i;
    push_ok = (cnt_q < CW'(FIFO_DEPTH)) || pop;
    for (int i = 0; i < NE; i++) begin
      rr_mask[i] = (i >= 32'(rr_q));
      sw_vec[i]  = wr_en && is_sw && sw_ok && (32'(sw_id) == i);
    end
    // Search from rr pointer upward first, then wrap to the lowest pending id.
    hi_pend  = pend_q & rr_mask;
    grant_id = (|hi_pend) ? first_set(hi_pend) : first_set(pend_q);
    push     = (|pend_q) && push_ok;
    for (int i = 0; i < NE; i++) begin
      grant_vec[i] = push && (32'(grant_id) == i);
    end

    set_vec = (evt_flat & mask_q) | sw_vec;
    ovf_vec = set_vec & pend_q & ~grant_vec;
    pend_d  = (pend_q & ~grant_vec) | set_vec;

    // A fresh overflow in the same cycle wins over the W1C.
    if (wr_en && is_status && bus.apb_pwdata[0]) ovf_d = 1'b0;
    if (|ovf_vec) begin
      ovf_d    = 1'b1;
      ovf_id_d = first_set(ovf_vec);
    end

`ifdef EVT_ROUTER_TIMESTAMP_EN
    entry = {ts_q, grant_id};
`else
    entry = grant_id;
`endif
    if (push) begin
      mem_d[wr_q] = entry;
      wr_d        = wr_q + AW'(1);
      rr_d        = (32'(grant_id) == NE - 1) ? '0 : grant_id + EVT_ID_WIDTH'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      mask_q   <= '0;
      pend_q   <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
      ovf_id_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
`ifdef EVT_ROUTER_TIMESTAMP_EN
      ts_q     <= '0;
`endif
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      ovf_id_q <= ovf_id_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
`ifdef EVT_ROUTER_TIMESTAMP_EN
      ts_q     <= ts_d;
`endif
    end
  end

  // Storage needs no reset: the head is gated by valid.
  always_ff @(posedge sys_clk_i) begin
    mem_q <= mem_d;
  end

  logic [EW-1:0] head;
  assign head              = mem_q[rd_q];
  assign bus.apb_pready    = 1'b1;
  assign bus.event_valid_o = (cnt_q != '0);
  assign bus.event_data_o  = bus.event_valid_o ? head[EVT_ID_WIDTH-1:0] : '0;
  assign overflow_irq_o    = ovf_q;
`ifdef EVT_ROUTER_TIMESTAMP_EN
  assign event_ts_o        = bus.event_valid_o ? head[EW-1 -: 16] : 16'h0;
`endif
endmodule

// File: tb/tb_pulp_io_evt_router.sv
// Randomised + directed bench for pulp_io_evt_router with a queue-based reference model and scoreboard.
module tb_pulp_io_evt_router;
  localparam int NP = 32, EPP = 4, DEPTH = 8, IDW = 8, AWID = 12;
  localparam int NE = NP * EPP;
  localparam int NW = (NE + 31) / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0][EPP-1:0] ev;
  logic irq;
`ifdef EVT_ROUTER_TIMESTAMP_EN
  logic [15:0] ts_o;
`endif

  pulp_io_evt_router_if #(.APB_ADDR_WIDTH(AWID), .EVT_ID_WIDTH(IDW)) bus ();

  pulp_io_evt_router #(
    .N_PERIPH(NP), .EVT_PER_PERIPH(EPP), .FIFO_DEPTH(DEPTH),
    .EVT_ID_WIDTH(IDW), .APB_ADDR_WIDTH(AWID)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .bus(bus.slave),
    .events_i(ev),
    .overflow_irq_o(irq)
`ifdef EVT_ROUTER_TIMESTAMP_EN
    ,
    .event_ts_o(ts_o)
`endif
  );

  int n_cmp = 0, n_err = 0;
  bit started = 0;

  // Reference model state
  bit m_pend [NE];
  bit m_mask [NE];
  int m_rr, m_cnt, m_ovf_id, m_ts;
  bit m_ovf;
  int exp_q[$];
  int exp_ts_q[$];
  int got_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_any_pend();
    for (int i = 0; i < NE; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    logic [31:0] r;
    int ai;
    r  = '0;
    ai = int'(a);
    if (ai[1:0] == 2'b00 && ai < 4 * NW) begin
      for (int b = 0; b < 32; b++)
        if ((ai / 4) * 32 + b < NE) r[b] = m_mask[(ai / 4) * 32 + b];
    end else if (ai == 'h80) begin
      r[0]    = m_ovf;
      r[1]    = (m_cnt == 0);
      r[2]    = (m_cnt == DEPTH);
      r[15:8] = 8'(m_cnt);
    end else if (ai == 'h84) begin
      r = 32'(m_ovf_id);
    end
    return r;
  endfunction

  function automatic bit model_err(input logic [11:0] a, input bit wr, input logic [31:0] d);
    int  ai;
    bit  known;
    ai    = int'(a);
    known = (ai[1:0] == 2'b00 && ai < 4 * NW) || ai == 'h80 || ai == 'h84 || ai == 'h88;
    return !known || (wr && ai == 'h88 && int'(d[7:0]) >= NE);
  endfunction

  always @(posedge clk) begin : model
    bit pop, wr;
    int a, sw, g, ov, idx;
    logic [31:0] d;
    bit setv [NE];
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        m_pend[i] = 1'b0;
        m_mask[i] = 1'b0;
      end
      m_rr = 0; m_cnt = 0; m_ovf = 1'b0; m_ovf_id = 0; m_ts = 0;
      exp_q.delete();
      exp_ts_q.delete();
    end else begin
      pop = (m_cnt != 0) && bus.event_ready_i;
      wr  = bus.apb_psel && bus.apb_penable && bus.apb_pwrite;
      a   = int'(bus.apb_paddr);
      d   = bus.apb_pwdata;
      sw  = -1;
      if (wr && a == 'h88 && int'(d[7:0]) < NE) sw = int'(d[7:0]);
      for (int id = 0; id < NE; id++)
        setv[id] = (ev[id / EPP][id % EPP] && m_mask[id]) || (id == sw);
      g = -1;
      if (m_any_pend() && (m_cnt < DEPTH || pop)) begin
        for (int i = 0; i < NE; i++) begin
          idx = (m_rr + i) % NE;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      end
      ov = -1;
      for (int id = 0; id < NE; id++)
        if (ov < 0 && setv[id] && m_pend[id] && id != g) ov = id;
      if (wr && a == 'h80 && d[0]) m_ovf = 1'b0;
      if (ov >= 0) begin
        m_ovf    = 1'b1;
        m_ovf_id = ov;
      end
      if (g >= 0) begin
        m_pend[g] = 1'b0;
        exp_q.push_back(g);
        exp_ts_q.push_back(m_ts);
        m_rr = (g + 1) % NE;
      end
      for (int id = 0; id < NE; id++) if (setv[id]) m_pend[id] = 1'b1;
      m_cnt = m_cnt + int'(g >= 0) - int'(pop);
      if (wr && a[1:0] == 2'b00 && a < 4 * NW)
        for (int b = 0; b < 32; b++)
          if ((a / 4) * 32 + b < NE) m_mask[(a / 4) * 32 + b] = d[b];
      m_ts = (m_ts + 1) & 'hFFFF;
    end
  end

  always @(negedge clk) begin : monitor
    int e;
    if (started) begin
      check("event_valid", longint'(bus.event_valid_o), longint'(m_cnt != 0));
      check("overflow_irq", longint'(irq), longint'(m_ovf));
      if (bus.event_valid_o && bus.event_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: actual=%0d expected=none", bus.event_data_o);
        end else begin
          e = exp_q.pop_front();
          check("event_id", longint'(bus.event_data_o), longint'(e));
`ifdef EVT_ROUTER_TIMESTAMP_EN
          check("event_ts", longint'(ts_o), longint'(exp_ts_q.pop_front()));
`else
          void'(exp_ts_q.pop_front());
`endif
          got_q.push_back(int'(bus.event_data_o));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    bus.apb_paddr   = a;
    bus.apb_pwdata  = d;
    bus.apb_pwrite  = wr;
    bus.apb_psel    = 1'b1;
    bus.apb_penable = 1'b0;
    tick();
    bus.apb_penable = 1'b1;
    @(negedge clk);
    rd  = bus.apb_prdata;
    err = bus.apb_pslverr;
    check("apb_pslverr", longint'(err), longint'(model_err(a, wr, d)));
    if (!wr) check("apb_prdata", longint'(rd), longint'(model_rd(a)));
    tick();
    bus.apb_psel    = 1'b0;
    bus.apb_penable = 1'b0;
    bus.apb_pwrite  = 1'b0;
  endtask

  task automatic pulse(input int id);
    ev = '0;
    ev[id / EPP][id % EPP] = 1'b1;
    tick();
    ev = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    ev = '0;
    bus.event_ready_i = 1'b1;
    while ((m_cnt != 0 || m_any_pend()) && n < budget) begin
      tick();
      n++;
    end
    tick();
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: actual=%0d cycles expected<%0d", n, budget);
    end
  endtask

  task automatic check_got(input string name, input int exp_ids[$]);
    check({name, "_count"}, got_q.size(), exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < got_q.size(); i++)
      check(name, got_q[i], exp_ids[i]);
  endtask

  initial begin
    logic [31:0] rd;
    logic err;
    int r, id;
    ev = '0;
    bus.apb_paddr = '0; bus.apb_pwdata = '0; bus.apb_pwrite = 1'b0;
    bus.apb_psel = 1'b0; bus.apb_penable = 1'b0; bus.event_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_valid", bus.event_valid_o, 0);
    check("reset_irq", irq, 0);
    apb(0, 12'h080, 0, rd, err);
    check("reset_status", rd, 32'h0000_0002);

    // Latency: id 9 driven in cycle c appears on the stream after edge c+2 for one cycle.
    for (int k = 0; k < NW; k++) apb(1, 12'(4 * k), 32'hFFFF_FFFF, rd, err);
    bus.event_ready_i = 1'b1;
    ev = '0;
    ev[2][1] = 1'b1;
    @(negedge clk); check("lat_c0", bus.event_valid_o, 0);
    @(posedge clk); #1 ev = '0;
    @(negedge clk); check("lat_c1", bus.event_valid_o, 0);
    @(negedge clk); check("lat_c2", bus.event_valid_o, 1);
    check("lat_data", bus.event_data_o, 9);
    @(negedge clk); check("lat_c3", bus.event_valid_o, 0);
    tick();

    // Round robin: pointer at 10 wraps to 0,3,7; then pointer 8 gives 9 before 5.
    got_q.delete();
    ev = '0;
    ev[0][0] = 1'b1; ev[0][3] = 1'b1; ev[1][3] = 1'b1;
    tick();
    drain(50);
    check_got("rr_a", '{0, 3, 7});
    got_q.delete();
    ev = '0;
    ev[1][1] = 1'b1; ev[2][1] = 1'b1;
    tick();
    drain(50);
    check_got("rr_b", '{9, 5});

    // Full FIFO holds the 9th id pending, then all nine drain without overflow.
    got_q.delete();
    bus.event_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) pulse(20 + i);
    repeat (3) tick();
    apb(0, 12'h080, 0, rd, err);
    check("full_status", rd, 32'h0000_0804);
    drain(100);
    check_got("full_order", '{20, 21, 22, 23, 24, 25, 26, 27, 28});
    apb(0, 12'h080, 0, rd, err);
    check("full_no_ovf", rd, 32'h0000_0002);

    // Overflow on id 4 while blocked, then W1C.
    got_q.delete();
    bus.event_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) pulse(30 + i);
    pulse(4);
    pulse(4);
    repeat (2) tick();
    apb(0, 12'h080, 0, rd, err);
    check("ovf_status", rd, 32'h0000_0805);
    apb(0, 12'h084, 0, rd, err);
    check("ovf_id", rd, 4);
    check("ovf_irq_set", irq, 1);
    apb(1, 12'h080, 32'h1, rd, err);
    check("ovf_irq_clr", irq, 0);
    drain(100);
    check_got("ovf_order", '{30, 31, 32, 33, 34, 35, 36, 37, 4});

    // Masks off: hardware pulse ignored, software injection bypasses mask, bad id errors.
    got_q.delete();
    for (int k = 0; k < NW; k++) apb(1, 12'(4 * k), 32'h0, rd, err);
    pulse(10);
    apb(1, 12'h088, 32'h85, rd, err);
    check("sw_bad_err", err, 1);
    apb(1, 12'h088, 32'h6, rd, err);
    check("sw_ok_err", err, 0);
    drain(50);
    check_got("sw_evt", '{6});
    apb(0, 12'h090, 0, rd, err);
    check("bad_addr_err", err, 1);
    check("bad_addr_data", rd, 0);
    apb(0, 12'h004, 0, rd, err);
    check("mask1_zero", rd, 0);

    // Randomised traffic with random masks, backpressure and APB side traffic.
    for (int k = 0; k < NW; k++) apb(1, 12'(4 * k), $urandom | $urandom, rd, err);
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 24);
      if (r < 5) begin
        ev = '0;
        case (r)
          0: apb(1, 12'h088, 32'($urandom_range(0, 140)), rd, err);
          1: apb(0, 12'h080, 0, rd, err);
          2: apb(1, 12'h080, 32'h1, rd, err);
          3: apb(0, 12'h084, 0, rd, err);
          default: apb(1, 12'(4 * $urandom_range(0, NW - 1)), $urandom, rd, err);
        endcase
      end else begin
        ev = '0;
        repeat ($urandom_range(0, 3)) begin
          id = $urandom_range(0, NE - 1);
          ev[id / EPP][id % EPP] = 1'b1;
        end
        bus.event_ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    drain(2000);
    apb(0, 12'h080, 0, rd, err);

    // Reset with three queued entries discards everything.
    apb(1, 12'h000, 32'hFFFF_FFFF, rd, err);
    bus.event_ready_i = 1'b0;
    pulse(1); pulse(2); pulse(3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.event_valid_o, 0);
    tick();
    apb(0, 12'h080, 0, rd, err);
    check("rst_status", rd, 32'h0000_0002);
    apb(0, 12'h000, 0, rd, err);
    check("rst_mask0", rd, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
